// File: rtl/instr_fetch_queue.sv
// Instruction fetch stage: owns the PC, issues one synchronous imem read per cycle,
// and buffers PC-tagged instructions in a small FIFO for decode.
module instr_fetch_queue #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16,
    parameter int DEPTH   = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               fetch_en,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W:0]   OCC_MAX = (CNT_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               inflight_q, inflight_d;
    logic [ADDR_W-1:0]  tag_q, tag_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [INSTR_W-1:0] instr_mem_q [DEPTH];
    logic [ADDR_W-1:0]  pc_mem_q    [DEPTH];

    logic [CNT_W:0]     occupancy;
    logic               push;
    logic               pop;

    // Credit check counts in-flight reads so a returning word always has a slot.
    assign occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
    assign imem_req  = reset_n & fetch_en & ~redirect_valid & (occupancy < OCC_MAX);
    assign imem_addr = pc_q;
    assign push      = inflight_q & ~redirect_valid;
    assign out_valid = (count_q != '0);
    assign pop       = out_valid & out_ready & ~redirect_valid;

    // Head is forced to zero when empty so the outputs read zero under reset.
    assign out_instr = out_valid ? instr_mem_q[rd_ptr_q] : '0;
    assign out_pc    = out_valid ? pc_mem_q[rd_ptr_q]    : '0;

    always_comb begin
        pc_d       = pc_q;
        inflight_d = inflight_q;
        tag_d      = tag_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        if (redirect_valid) begin
            pc_d       = redirect_pc;
            inflight_d = 1'b0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            inflight_d = imem_req;
            if (imem_req) begin
                tag_d = pc_q;
                pc_d  = pc_q + ADDR_W'(1);
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q       <= '0;
            inflight_q <= 1'b0;
            tag_q      <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            tag_q      <= tag_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage is data-only; validity comes from count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem_q[wr_ptr_q] <= imem_rdata;
            pc_mem_q[wr_ptr_q]    <= tag_q;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(push && !pop && (count_q == CNT_MAX)));

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: directed vector table, corner sequences,
// and randomized traffic compared against a queue-based reference model.
module tb_instr_fetch_queue;

    localparam int AW = 8;
    localparam int IW = 16;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          fetch_en;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic [IW-1:0] imem_rdata;
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] out_instr;
    logic [AW-1:0] out_pc;

    always #5 clk = ~clk;

    instr_fetch_queue #(.ADDR_W(AW), .INSTR_W(IW), .DEPTH(D)) dut (
        .clk(clk), .reset_n(reset_n), .fetch_en(fetch_en),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc)
    );

    logic [IW-1:0] mem [256];

    // Synchronous instruction memory.
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= mem[imem_addr];
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    // Reference model: a queue of {pc, instr}, the next fetch pc, and one pending read.
    typedef struct packed {
        logic [AW-1:0] pc;
        logic [IW-1:0] instr;
    } ent_t;

    ent_t          mq[$];
    logic [AW-1:0] m_pc;
    bit            m_inf;
    logic [AW-1:0] m_tag;

    task automatic model_reset();
        mq.delete();
        m_pc  = '0;
        m_inf = 1'b0;
        m_tag = '0;
    endtask

    function automatic bit m_req();
        return fetch_en && !redirect_valid && ((mq.size() + int'(m_inf)) < D);
    endfunction

    task automatic model_check(input string nm);
        check({nm, ".req"},   32'(imem_req),  32'(m_req()));
        check({nm, ".addr"},  32'(imem_addr), 32'(m_pc));
        check({nm, ".valid"}, 32'(out_valid), 32'(mq.size() > 0));
        if (mq.size() > 0) begin
            check({nm, ".pc"},    32'(out_pc),    32'(mq[0].pc));
            check({nm, ".instr"}, 32'(out_instr), 32'(mq[0].instr));
        end
    endtask

    task automatic model_tick();
        bit r;
        r = m_req();
        if (redirect_valid) begin
            mq.delete();
            m_inf = 1'b0;
            m_pc  = redirect_pc;
        end else begin
            if (mq.size() > 0 && out_ready) void'(mq.pop_front());
            if (m_inf) mq.push_back('{pc: m_tag, instr: mem[m_tag]});
            if (r) begin
                m_tag = m_pc;
                m_pc  = m_pc + 8'd1;
            end
            m_inf = r;
        end
    endtask

    task automatic drive(input bit fe, input bit rv, input logic [AW-1:0] rpc, input bit rdy);
        fetch_en       = fe;
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
    endtask

    task automatic tick_edge();
        @(posedge clk);
        model_tick();
        #1;
    endtask

    task automatic cyc(input bit fe, input bit rv, input logic [AW-1:0] rpc, input bit rdy,
                       input string nm);
        drive(fe, rv, rpc, rdy);
        @(negedge clk);
        model_check(nm);
    endtask

    task automatic step(input bit fe, input bit rv, input logic [AW-1:0] rpc, input bit rdy,
                        input string nm);
        cyc(fe, rv, rpc, rdy, nm);
        tick_edge();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        drive(1'b1, 1'b0, '0, 1'b1);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.req",   32'(imem_req),  32'd0);
        check("rst.addr",  32'(imem_addr), 32'd0);
        check("rst.valid", 32'(out_valid), 32'd0);
        check("rst.pc",    32'(out_pc),    32'd0);
        check("rst.instr", 32'(out_instr), 32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    typedef struct {
        bit            rst;
        bit            fe;
        bit            rdy;
        bit            e_req;
        logic [AW-1:0] e_addr;
        bit            e_v;
        logic [AW-1:0] e_pc;
    } vec_t;

    vec_t tbl[17];

    initial begin
        logic [IW-1:0] e_instr;
        for (int i = 0; i < 256; i++) mem[i] = IW'(i * 16'h0101);
        imem_rdata = '0;
        reset_n    = 1'b0;
        drive(1'b0, 1'b0, '0, 1'b0);

        // Free-running from reset, then back-pressure from reset.
        tbl[0]  = '{1, 1, 1, 1, 8'd0, 0, 8'd0};
        tbl[1]  = '{0, 1, 1, 1, 8'd1, 0, 8'd0};
        tbl[2]  = '{0, 1, 1, 1, 8'd2, 1, 8'd0};
        tbl[3]  = '{0, 1, 1, 1, 8'd3, 1, 8'd1};
        tbl[4]  = '{0, 1, 1, 1, 8'd4, 1, 8'd2};
        tbl[5]  = '{0, 1, 1, 1, 8'd5, 1, 8'd3};
        tbl[6]  = '{1, 1, 0, 1, 8'd0, 0, 8'd0};
        tbl[7]  = '{0, 1, 0, 1, 8'd1, 0, 8'd0};
        tbl[8]  = '{0, 1, 0, 1, 8'd2, 1, 8'd0};
        tbl[9]  = '{0, 1, 0, 1, 8'd3, 1, 8'd0};
        tbl[10] = '{0, 1, 0, 0, 8'd4, 1, 8'd0};
        tbl[11] = '{0, 1, 0, 0, 8'd4, 1, 8'd0};
        tbl[12] = '{0, 1, 1, 0, 8'd4, 1, 8'd0};
        tbl[13] = '{0, 1, 1, 1, 8'd4, 1, 8'd1};
        tbl[14] = '{0, 1, 1, 1, 8'd5, 1, 8'd2};
        tbl[15] = '{0, 1, 1, 1, 8'd6, 1, 8'd3};
        tbl[16] = '{0, 1, 1, 1, 8'd7, 1, 8'd4};

        for (int i = 0; i < 17; i++) begin
            if (tbl[i].rst) do_reset();
            drive(tbl[i].fe, 1'b0, '0, tbl[i].rdy);
            @(negedge clk);
            check($sformatf("vec%0d.req", i),   32'(imem_req),  32'(tbl[i].e_req));
            check($sformatf("vec%0d.addr", i),  32'(imem_addr), 32'(tbl[i].e_addr));
            check($sformatf("vec%0d.valid", i), 32'(out_valid), 32'(tbl[i].e_v));
            if (tbl[i].e_v) begin
                e_instr = {tbl[i].e_pc, tbl[i].e_pc};
                check($sformatf("vec%0d.pc", i),    32'(out_pc),    32'(tbl[i].e_pc));
                check($sformatf("vec%0d.instr", i), 32'(out_instr), 32'(e_instr));
            end
            tick_edge();
        end

        // Redirect while three entries are buffered and addr 3 is in flight.
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 0, '0, 0, "redir.fill");
        cyc(1, 1, 8'h80, 0, "redir.R");
        check("redir.R.req", 32'(imem_req), 32'd0);
        tick_edge();
        cyc(1, 0, '0, 1, "redir.R1");
        check("redir.R1.valid", 32'(out_valid), 32'd0);
        check("redir.R1.req",   32'(imem_req),  32'd1);
        check("redir.R1.addr",  32'(imem_addr), 32'h80);
        tick_edge();
        cyc(1, 0, '0, 1, "redir.R2");
        check("redir.R2.valid", 32'(out_valid), 32'd0);
        tick_edge();
        cyc(1, 0, '0, 1, "redir.R3");
        check("redir.R3.valid", 32'(out_valid), 32'd1);
        check("redir.R3.pc",    32'(out_pc),    32'h80);
        check("redir.R3.instr", 32'(out_instr), 32'h8080);
        tick_edge();
        cyc(1, 0, '0, 1, "redir.R4");
        check("redir.R4.pc", 32'(out_pc), 32'h81);
        tick_edge();

        // PC wrap-around 0xFF -> 0x00.
        step(1, 1, 8'hFE, 1, "wrap.R");
        step(1, 0, '0, 1, "wrap.R1");
        step(1, 0, '0, 1, "wrap.R2");
        for (int i = 0; i < 4; i++) begin
            logic [AW-1:0] ep;
            ep = 8'hFE + AW'(i);
            cyc(1, 0, '0, 1, "wrap.seq");
            check($sformatf("wrap.pc%0d", i), 32'(out_pc), 32'(ep));
            check($sformatf("wrap.v%0d", i),  32'(out_valid), 32'd1);
            tick_edge();
        end

        // fetch_en dropped the cycle after one request.
        do_reset();
        step(1, 0, '0, 1, "fe.c0");
        cyc(0, 0, '0, 1, "fe.c1");
        check("fe.c1.req", 32'(imem_req), 32'd0);
        tick_edge();
        cyc(0, 0, '0, 1, "fe.c2");
        check("fe.c2.valid", 32'(out_valid), 32'd1);
        check("fe.c2.pc",    32'(out_pc),    32'd0);
        tick_edge();
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, '0, 1, "fe.drain");
            check($sformatf("fe.drain%0d.valid", i), 32'(out_valid), 32'd0);
            check($sformatf("fe.drain%0d.req", i),   32'(imem_req),  32'd0);
            tick_edge();
        end

        // Asynchronous reset mid-stream with two entries buffered.
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 0, '0, 0, "arst.fill");
        drive(1, 0, '0, 0);
        @(negedge clk);
        check("arst.pre.valid", 32'(out_valid), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("arst.req",   32'(imem_req),  32'd0);
        check("arst.addr",  32'(imem_addr), 32'd0);
        check("arst.valid", 32'(out_valid), 32'd0);
        check("arst.pc",    32'(out_pc),    32'd0);
        check("arst.instr", 32'(out_instr), 32'd0);
        model_reset();
        @(posedge clk);
        #1 reset_n = 1'b1;
        cyc(1, 0, '0, 1, "arst.rel");
        check("arst.rel.req",  32'(imem_req),  32'd1);
        check("arst.rel.addr", 32'(imem_addr), 32'd0);
        tick_edge();
        for (int i = 0; i < 4; i++) step(1, 0, '0, 1, "arst.run");

        // Randomized traffic against the reference model.
        do_reset();
        for (int i = 0; i < 800; i++) begin
            bit            fe, rv, rdy;
            logic [AW-1:0] rpc;
            fe  = ($urandom % 8) != 0;
            rdy = ($urandom % 3) != 0;
            rv  = ($urandom % 20) == 0;
            rpc = AW'($urandom);
            step(fe, rv, rpc, rdy, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Instruction fetch stage directly upstream of the control unit / ALU pair in the in-order processor. Owns the program counter and issues one read per cycle to a synchronous 16-bit instruction memory. Buffers returned instructions, tagged with their PC, in a small FIFO, and hands them to decode over a valid/ready handshake. Supports a single-cycle PC redirect that flushes all buffered and in-flight fetches.

## Interface
- ADDR_W, 8, PC and instruction-memory address width (256-entry memory)
- INSTR_W, 16, instruction width
- DEPTH, 4, prefetch FIFO entries (power of two, ≥2)

- clk  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- fetch_en  in  1  permits new memory requests
- redirect_valid  in  1  load redirect_pc and flush (1-cycle pulse)
- redirect_pc  in  ADDR_W  new fetch address
- imem_req  out  1  read request this cycle
- imem_addr  out  ADDR_W  read address; equals pc
- imem_rdata  in  INSTR_W  read data, valid exactly 1 cycle after imem_req
- out_valid  out  1  FIFO head holds an instruction
- out_ready  in  1  decode accepts head this cycle
- out_instr  out  INSTR_W  head instruction
- out_pc  out  ADDR_W  address the head instruction was fetched from

## Operation
- State: pc, inflight flag plus inflight-pc tag, FIFO storage, rd/wr pointers, count (0..DEPTH).
- Request rule: imem_req = fetch_en & !redirect_valid & (count + inflight < DEPTH). Uses registered count, with no credit for a same-cycle pop. On request: inflight<=1, tag<=pc, pc<=pc+1.
- pc is ADDR_W bits and wraps 255→0 with no flag.
- Response: if inflight was set and no redirect occurred this cycle, {tag, imem_rdata} is written at the FIFO tail. Space is guaranteed by the credit rule, so no overflow check is needed and overflow is an assertion failure.
- Pop: when out_valid & out_ready, the head advances. Push and pop in the same cycle leave count unchanged. With count==0, a push is not bypassed to the output.
- out_instr/out_pc are driven from the FIFO head. They must hold stable while out_valid & !out_ready.
- Redirect takes priority over everything in that cycle:
  - pc<=redirect_pc.
  - FIFO cleared (count<=0, pointers<=0).
  - Any response arriving this cycle is discarded, and inflight<=0.
  - No request is issued this cycle.
  - A pop in the same cycle is ignored, since decode sees the flush.
- fetch_en low: no new requests. An in-flight response still completes into the FIFO, and draining continues.

## Timing
- Reset values (asynchronous, while reset_n=0):
  - pc=0, inflight=0, count=0, pointers=0
  - imem_req=0 (it is combinational on state, so it is forced low)
  - out_valid=0, out_instr=0, out_pc=0
- Latency from request to out_valid is 2 cycles. Cycle N: imem_req, imem_addr=A. Cycle N+1: data written. Cycle N+2: out_valid=1, out_pc=A.
- Throughput with out_ready held high: 1 instruction/cycle sustained; steady-state count+inflight ≤2.
- Back-pressure: with out_ready low, requests continue until count+inflight==DEPTH, then imem_req drops. The first pop re-enables a request in the following cycle.
- Redirect at cycle R:
  - out_valid=0 in R+1.
  - First request to redirect_pc in R+1 (if fetch_en).
  - That instruction appears at out in R+3.
- Reset deasserting mid-operation: first request occurs in the first cycle after release with fetch_en high, at addr 0.

## Test plan
- Reset release, fetch_en=1, out_ready=1, mem[i]=i*0x0101:
  - imem_addr runs 0,1,2,… from cycle 0.
  - out_valid rises at cycle 2 with out_pc=0, out_instr=0x0000.
  - Then one instruction per cycle with out_pc incrementing.
- out_ready=0 from start:
  - Exactly 4 requests are issued (addr 0..3), then imem_req=0 and count=4.
  - Raising out_ready yields pcs 0,1,2,3,4 in order with no gaps or duplicates.
- Redirect to 0x80 while count=3 and a response is in flight:
  - out_valid=0 next cycle, and the in-flight word is never output.
  - The next out_pc values are 0x80, 0x81.
- Wrap-around: redirect to 0xFE, free-running. out_pc sequence is 0xFE, 0xFF, 0x00, 0x01.
- fetch_en dropped the cycle after a request: that one response still emerges, then imem_req stays 0 and out_valid falls after the drain.
- reset_n asserted mid-stream with count=2:
  - All outputs return to reset values immediately, without waiting for a clock edge.
  - After release, fetching restarts at addr 0.
